// File: rtl/avalon_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_arb_pkg
// Function : Shared types and helpers for the Avalon-MM burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package avalon_arb_pkg;

    localparam int MAX_HOSTS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } arb_state_t;

    function automatic logic [2:0] onehot2idx(input logic [MAX_HOSTS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_HOSTS; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_burst_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Function : Combinational round-robin pick; first requester at or after
//            rr_ptr wins, optionally preceded by a fixed host-0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import avalon_arb_pkg::*;
#(
    parameter int NUM_HOSTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_HOSTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    input  logic                 prio0,
    output logic [NUM_HOSTS-1:0] winner
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (prio0 && req[0]) begin
            winner[0] = 1'b1;
            w_found   = 1'b1;
        end
        for (int k = 0; k < NUM_HOSTS; k++) begin
            w_idx = IDX_W'((int'(rr_ptr) + k) % NUM_HOSTS);
            if (!w_found && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/avalon_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_burst_arbiter
// Function : N-host to 1-agent Avalon-MM burst arbiter, registered round-robin
//            grant held for a whole burst. AVALON_ARB_PRIO0_EN gives host 0
//            fixed priority at arbitration time.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_burst_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_HOSTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_HOSTS*ADDR_W-1:0]     h_address,
    input  logic [NUM_HOSTS*DATA_W/8-1:0]   h_byteenable,
    input  logic [NUM_HOSTS-1:0]            h_read,
    input  logic [NUM_HOSTS-1:0]            h_write,
    input  logic [NUM_HOSTS*DATA_W-1:0]     h_writedata,
    input  logic [NUM_HOSTS*BURST_W-1:0]    h_burstcount,
    output logic [NUM_HOSTS*DATA_W-1:0]     h_readdata,
    output logic [NUM_HOSTS-1:0]            h_waitrequest,
    output logic [NUM_HOSTS-1:0]            h_readdatavalid,
    output logic [ADDR_W-1:0]               m_address,
    output logic [DATA_W/8-1:0]             m_byteenable,
    output logic                            m_read,
    output logic                            m_write,
    output logic [DATA_W-1:0]               m_writedata,
    output logic [BURST_W-1:0]              m_burstcount,
    input  logic [DATA_W-1:0]               m_readdata,
    input  logic                            m_waitrequest,
    input  logic                            m_readdatavalid,
    output logic [NUM_HOSTS-1:0]            grant
);

    localparam int                 BE_W  = DATA_W / 8;
    localparam int                 IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam logic [BURST_W-1:0] c_ONE = BURST_W'(1);

    arb_state_t             r_state, w_state_nxt;
    logic [NUM_HOSTS-1:0]   r_grant, w_grant_nxt, w_req, w_winner;
    logic [IDX_W-1:0]       r_rr_ptr, w_rr_nxt, w_owner, w_owner_inc;
    logic [BURST_W-1:0]     r_beat_cnt, w_beat_nxt, r_len, w_len_nxt, w_cmd_len, w_cnt_inc;
    logic                   w_own_read, w_own_write, w_done, w_prio0;
    logic                   w_pass_wait, w_rd_phase;

`ifdef AVALON_ARB_PRIO0_EN
    assign w_prio0 = 1'b1;
`else
    assign w_prio0 = 1'b0;
`endif

    assign w_req = h_read | h_write;

    rr_pick #(
        .NUM_HOSTS (NUM_HOSTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req    (w_req),
        .rr_ptr (r_rr_ptr),
        .prio0  (w_prio0),
        .winner (w_winner)
    );

    assign w_owner     = IDX_W'(onehot2idx(MAX_HOSTS'(r_grant)));
    assign w_owner_inc = IDX_W'((int'(w_owner) + 1) % NUM_HOSTS);

    // One-hot mux of the owner's command; everything reads zero when idle.
    always_comb begin
        m_address    = '0;
        m_byteenable = '0;
        m_writedata  = '0;
        m_burstcount = '0;
        w_own_read   = 1'b0;
        w_own_write  = 1'b0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (r_grant[i]) begin
                m_address    = h_address[i*ADDR_W +: ADDR_W];
                m_byteenable = h_byteenable[i*BE_W +: BE_W];
                m_writedata  = h_writedata[i*DATA_W +: DATA_W];
                m_burstcount = h_burstcount[i*BURST_W +: BURST_W];
                w_own_read   = h_read[i];
                w_own_write  = h_write[i];
            end
        end
    end

    assign m_read      = (r_state == GRANT) && w_own_read;
    assign m_write     = ((r_state == GRANT) && w_own_write && !w_own_read) ||
                         ((r_state == WR_DATA) && w_own_write);
    assign w_pass_wait = (r_state == GRANT) || (r_state == WR_DATA);
    assign w_rd_phase  = (r_state == RD_DATA);
    assign w_cmd_len   = (m_burstcount == '0) ? c_ONE : m_burstcount;
    assign w_cnt_inc   = r_beat_cnt + c_ONE;
    assign grant       = r_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_len_nxt   = r_len;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_own_read && !m_waitrequest) begin
                    w_len_nxt   = w_cmd_len;
                    w_beat_nxt  = '0;
                    w_state_nxt = RD_DATA;
                end else if (w_own_write && !m_waitrequest) begin
                    w_len_nxt  = w_cmd_len;
                    w_beat_nxt = c_ONE;
                    if (w_cmd_len == c_ONE) w_done = 1'b1;
                    else                    w_state_nxt = WR_DATA;
                end else if (!w_own_read && !w_own_write) begin
                    // Host withdrew before acceptance: release without advancing rr_ptr.
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            RD_DATA: begin
                if (m_readdatavalid) begin
                    w_beat_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) w_done = 1'b1;
                end
            end
            WR_DATA: begin
                if (w_own_write && !m_waitrequest) begin
                    w_beat_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) w_done = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_done) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
`ifdef AVALON_ARB_PRIO0_EN
            if (w_owner != '0) w_rr_nxt = w_owner_inc;
`else
            w_rr_nxt = w_owner_inc;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_len      <= w_len_nxt;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_HOSTS; gi++) begin : g_host
            assign h_waitrequest[gi]   = (r_grant[gi] && w_pass_wait) ? m_waitrequest : 1'b1;
            assign h_readdatavalid[gi] = r_grant[gi] && w_rd_phase && m_readdatavalid;
            assign h_readdata[gi*DATA_W +: DATA_W] = (r_grant[gi] && w_rd_phase) ? m_readdata : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_avalon_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_burst_arbiter
// Function : Directed self-checking bench for avalon_burst_arbiter (4 hosts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_burst_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 5;
    localparam int BEW = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*AW-1:0] h_address;
    logic [N*BEW-1:0] h_byteenable;
    logic [N-1:0]    h_read, h_write;
    logic [N*DW-1:0] h_writedata;
    logic [N*BW-1:0] h_burstcount;
    logic [N*DW-1:0] h_readdata;
    logic [N-1:0]    h_waitrequest, h_readdatavalid, grant;
    logic [AW-1:0]   m_address;
    logic [BEW-1:0]  m_byteenable;
    logic            m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [DW-1:0]   m_writedata, m_readdata;
    logic [BW-1:0]   m_burstcount;

    avalon_burst_arbiter #(
        .NUM_HOSTS (N), .ADDR_W (AW), .DATA_W (DW), .BURST_W (BW)
    ) u_dut (
        .clk (clk), .reset (reset),
        .h_address (h_address), .h_byteenable (h_byteenable),
        .h_read (h_read), .h_write (h_write), .h_writedata (h_writedata),
        .h_burstcount (h_burstcount), .h_readdata (h_readdata),
        .h_waitrequest (h_waitrequest), .h_readdatavalid (h_readdatavalid),
        .m_address (m_address), .m_byteenable (m_byteenable),
        .m_read (m_read), .m_write (m_write), .m_writedata (m_writedata),
        .m_burstcount (m_burstcount), .m_readdata (m_readdata),
        .m_waitrequest (m_waitrequest), .m_readdatavalid (m_readdatavalid),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int rd_left[N], wr_left[N], bc[N], wr_done[N], rdv_cnt[N], rd_sum[N];
    int pending, data_ctr, wr_m_acc, wr_sum, viol, gap;
    bit wtoggle_mode, wtog, stray;
    int order[$];
    int gaps[$];
    logic [N-1:0] last_g;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int ord(input int k);
        return (order.size() > k) ? order[k] : -1;
    endfunction

    function automatic bit busy();
        bit b = (pending > 0) || (grant != '0);
        for (int i = 0; i < N; i++) if (rd_left[i] > 0 || wr_left[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic apply_hosts();
        for (int i = 0; i < N; i++) begin
            h_read[i]                  = (rd_left[i] > 0);
            h_write[i]                 = (wr_left[i] > 0);
            h_burstcount[i*BW +: BW]   = BW'(bc[i]);
            h_address[i*AW +: AW]      = AW'(32'h1000 * (i + 1));
            h_byteenable[i*BEW +: BEW] = '1;
            h_writedata[i*DW +: DW]    = DW'(200 + wr_done[i]);
        end
    endtask

    // One clock: agent drives at negedge, everything is observed 1ns later,
    // hosts update 1ns after the posedge.
    task automatic cycle();
        logic [N-1:0] acc_r, acc_w;
        @(negedge clk);
        if (stray) begin
            m_readdatavalid = 1'b1; m_readdata = 32'hDEAD; stray = 1'b0;
        end else if (pending > 0) begin
            m_readdatavalid = 1'b1; m_readdata = DW'(data_ctr); data_ctr++; pending--;
        end else begin
            m_readdatavalid = 1'b0; m_readdata = '0;
        end
        if (wtoggle_mode) begin wtog = ~wtog; m_waitrequest = wtog; end
        else m_waitrequest = 1'b0;
        #1;
        if (m_read && !m_waitrequest) pending += (m_burstcount == '0) ? 1 : int'(m_burstcount);
        if (m_write && !m_waitrequest) begin wr_m_acc++; wr_sum += int'(m_writedata); end
        for (int i = 0; i < N; i++) begin
            acc_r[i] = h_read[i] & ~h_waitrequest[i];
            acc_w[i] = h_write[i] & ~h_waitrequest[i];
            if (h_readdatavalid[i]) begin
                rdv_cnt[i]++;
                rd_sum[i] += int'(h_readdata[i*DW +: DW]);
            end
            if (!grant[i] && (!h_waitrequest[i] || h_readdatavalid[i] || h_readdata[i*DW +: DW] != '0))
                viol++;
        end
        if (grant == '0) gap++;
        else if (last_g == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
            gaps.push_back(gap);
            gap = 0;
        end
        last_g = grant;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (acc_r[i]) rd_left[i]--;
            if (acc_w[i]) begin wr_left[i]--; wr_done[i]++; end
        end
        apply_hosts();
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int c = 0;
        do begin cycle(); c++; end while (busy() && c < maxc);
        check(tag, 32'(!busy()), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_left[i] = 0; wr_left[i] = 0; bc[i] = 1; wr_done[i] = 0; rdv_cnt[i] = 0; rd_sum[i] = 0;
        end
        pending = 0; data_ctr = 100; wr_m_acc = 0; wr_sum = 0; viol = 0; gap = 0;
        wtoggle_mode = 1'b0; wtog = 1'b0; stray = 1'b0; last_g = '0;
        order.delete(); gaps.delete();
        m_readdatavalid = 1'b0; m_readdata = '0; m_waitrequest = 1'b0;
        apply_hosts();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int exp3[8];
    int gmin, gmax, tot;

    initial begin
        reset = 1'b1;
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_wait", 32'(h_waitrequest), 32'hF);
        check("rst_rdv", 32'(h_readdatavalid), 32'd0);
        check("rst_rdata", 32'(h_readdata != '0), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a read burst
        rd_left[0] = 1; bc[0] = 8; apply_hosts();
        repeat (3) cycle();
        check("t1_grant_mid", 32'(grant), 32'd1);
        reset = 1'b1;
        #1;
        check("t1_grant_rst", 32'(grant), 32'd0);
        check("t1_wait_rst", 32'(h_waitrequest), 32'hF);
        check("t1_mread_rst", 32'(m_read), 32'd0);
        do_reset();

        // Simultaneous host0 read x8 and host1 write x4
        rd_left[0] = 1; bc[0] = 8; wr_left[1] = 4; bc[1] = 4; apply_hosts();
        cycle();
        check("t2_grant0", 32'(grant), 32'd1);
        check("t2_mread", 32'(m_read), 32'd1);
        check("t2_maddr", m_address, 32'h1000);
        check("t2_mbc", 32'(m_burstcount), 32'd8);
        check("t2_h1_wait", 32'(h_waitrequest[1]), 32'd1);
        run_until_idle("t2_done", 200);
        check("t2_rdv0", rdv_cnt[0], 8);
        check("t2_rdv1", rdv_cnt[1], 0);
        check("t2_rdsum0", rd_sum[0], 828);
        check("t2_wr1", wr_done[1], 4);
        check("t2_mwr", wr_m_acc, 4);
        check("t2_wrsum", wr_sum, 806);
        check("t2_ord0", ord(0), 0);
        check("t2_ord1", ord(1), 1);
        check("t2_viol", viol, 0);

        // All four hosts: two single-beat reads each
        do_reset();
`ifdef AVALON_ARB_PRIO0_EN
        exp3 = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int i = 0; i < N; i++) begin rd_left[i] = 2; bc[i] = 1; end
        apply_hosts();
        run_until_idle("t3_done", 200);
        for (int k = 0; k < 8; k++) check($sformatf("t3_ord%0d", k), ord(k), exp3[k]);
        gmin = 99; gmax = -1;
        for (int k = 1; k < gaps.size(); k++) begin
            if (gaps[k] < gmin) gmin = gaps[k];
            if (gaps[k] > gmax) gmax = gaps[k];
        end
        check("t3_gap_min", gmin, 1);
        check("t3_gap_max", gmax, 1);
        check("t3_viol", viol, 0);

        // Write x4 under toggling waitrequest
        do_reset();
        wtoggle_mode = 1'b1;
        wr_left[2] = 4; bc[2] = 4; apply_hosts();
        run_until_idle("t4_done", 200);
        check("t4_mwr", wr_m_acc, 4);
        check("t4_hwr", wr_done[2], 4);
        check("t4_wrsum", wr_sum, 806);
        check("t4_bursts", order.size(), 1);

        // burstcount 0 read, then a stray readdatavalid while idle
        do_reset();
        rd_left[3] = 1; bc[3] = 0; apply_hosts();
        run_until_idle("t5_done", 100);
        check("t5_rdv3", rdv_cnt[3], 1);
        check("t5_bursts", order.size(), 1);
        stray = 1'b1;
        cycle();
        tot = 0;
        for (int i = 0; i < N; i++) tot += rdv_cnt[i];
        check("t5_stray", tot, 1);
        check("t5_viol", viol, 0);

        // Host1 bursting while host0 and host2 start requesting
        do_reset();
        rd_left[1] = 1; bc[1] = 4; apply_hosts();
        repeat (2) cycle();
        rd_left[0] = 1; rd_left[2] = 1; bc[0] = 1; bc[2] = 1; apply_hosts();
        run_until_idle("t6_done", 200);
        check("t6_rdv1", rdv_cnt[1], 4);
        check("t6_ord0", ord(0), 1);
`ifdef AVALON_ARB_PRIO0_EN
        check("t6_ord1", ord(1), 0);
        check("t6_ord2", ord(2), 2);
`else
        check("t6_ord1", ord(1), 2);
        check("t6_ord2", ord(2), 0);
`endif
        check("t6_viol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
